// File: rtl/booth_seq_pkg.sv
// booth_seq_pkg: shared definitions for the sequential Booth multiplier.
//   DEFAULT_WIDTH : default operand width
//   state_t       : FSM state encoding (IDLE, CALC, DONE)
package booth_seq_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
// Performs the add/subtract selected by {q[0], q_1}, then an arithmetic
// right shift of {A, Q, q_1} by one bit.
//   a, q, q_1, m                : current accumulator, multiplier, history bit, multiplicand
//   a_next, q_next, q_1_next    : values after the step
module booth_step
   import booth_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic             q_1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_1_next
);

   // WIDTH+1 bit arithmetic; carry-out simply falls off the top, which keeps
   // -2^(WIDTH-1) as a multiplicand representable after negation.
   logic [WIDTH:0] sum;

   always_comb begin
      sum = a;
      case ({q[0], q_1})
         2'b10:   sum = a - m;
         2'b01:   sum = a + m;
         default: sum = a;
      endcase
      a_next   = {sum[WIDTH], sum[WIDTH:1]};
      q_next   = {sum[0], q[WIDTH-1:1]};
      q_1_next = q[0];
   end

endmodule

// File: rtl/booth_seq.sv
// booth_seq: sequential radix-2 Booth signed multiplier.
// One Booth step per clock in CALC; fixed latency of WIDTH steps, then a
// single DONE cycle before returning to IDLE.
//   clk     : clock, rising edge
//   reset   : synchronous, active-low
//   start   : begin a multiply (sampled only in IDLE)
//   mcand   : signed multiplicand, WIDTH bits
//   mplr    : signed multiplier, WIDTH bits
//   busy    : high while in CALC
//   done    : one-cycle pulse while in DONE
//   product : signed 2*WIDTH result, held until the next completed multiply
module booth_seq
   import booth_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplr,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_t           state;
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic             q_1;
   logic [WIDTH:0]   m;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   a_n;
   logic [WIDTH-1:0] q_n;
   logic             q_1_n;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a        (a),
      .q        (q),
      .q_1      (q_1),
      .m        (m),
      .a_next   (a_n),
      .q_next   (q_n),
      .q_1_next (q_1_n)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         a       <= '0;
         q       <= '0;
         q_1     <= 1'b0;
         m       <= '0;
         cnt     <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  m     <= {mcand[WIDTH-1], mcand};
                  q     <= mplr;
                  a     <= '0;
                  q_1   <= 1'b0;
                  cnt   <= CW'(WIDTH - 1);
                  state <= S_CALC;
                  busy  <= 1'b1;
               end
            end
            S_CALC: begin
               a   <= a_n;
               q   <= q_n;
               q_1 <= q_1_n;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  // Final step: publish the low 2*WIDTH bits of {A,Q} directly
                  // from the step outputs so product is valid in DONE.
                  product <= {a_n[WIDTH-1:0], q_n};
                  state   <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq.sv
// tb_booth_seq: scoreboard bench for booth_seq (WIDTH=4).
// Stimulus pushes expected products; a negedge monitor pops on done.
module tb_booth_seq;

   localparam int WIDTH = 4;

   logic               clk;
   logic               reset;
   logic               start;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplr;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   int checks = 0;
   int errors = 0;

   logic [2*WIDTH-1:0] sb[$];
   bit                 b2b_mode = 0;
   int                 cyc = 0;
   int                 last_done_cyc = -1;

   booth_seq #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mcand   (mcand),
      .mplr    (mplr),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected product.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (product 0x%0h)", product);
         end else begin
            logic [2*WIDTH-1:0] e;
            e = sb.pop_front();
            chk("product", 32'(product), 32'(e));
         end
         if (b2b_mode && last_done_cyc >= 0)
            chk("done_spacing", 32'(cyc - last_done_cyc), 32'(WIDTH + 2));
         last_done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One multiply from IDLE with a start pulse; optionally pulses start with
   // other operands during CALC, which must be ignored.
   task automatic run_op(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] mp,
                         input logic [2*WIDTH-1:0] exp, input bit inject, input string nm);
      int bcnt, dcnt, dat;
      mcand = mc; mplr = mp; start = 1;
      sb.push_back(exp);
      tick();                       // E0
      start = 0;
      mcand = ~mc; mplr = ~mp;      // in-flight operands must not follow inputs
      bcnt = 0; dcnt = 0; dat = -1;
      for (int i = 0; i < WIDTH + 4; i++) begin
         if (busy) bcnt++;
         if (done) begin dcnt++; dat = i; end
         if (inject && i == 1) begin start = 1; mcand = 4'h7; mplr = 4'h7; end
         else start = 0;
         tick();
      end
      chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(WIDTH));
      chk({nm, "_done_cycles"}, 32'(dcnt), 32'd1);
      chk({nm, "_done_latency"}, 32'(dat), 32'(WIDTH));
      chk({nm, "_held"}, 32'(product), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 0; start = 0; mcand = '0; mplr = '0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_product", 32'(product), 0);
      reset = 1;
      tick();

      run_op(4'd3,  4'hE, 8'hFA, 0, "3x-2");
      run_op(4'h8,  4'h8, 8'h40, 0, "-8x-8");
      run_op(4'h8,  4'h7, 8'hC8, 0, "-8x7");
      run_op(4'h0,  4'hF, 8'h00, 0, "0x-1");
      run_op(4'h7,  4'h7, 8'h31, 0, "7x7");
      run_op(4'hF,  4'hF, 8'h01, 0, "-1x-1");
      run_op(4'h5,  4'hD, 8'hF1, 1, "5x-3_inject");

      // Reset in flight: start at E0, reset sampled at E0+2.
      mcand = 4'h3; mplr = 4'h3; start = 1;
      tick();
      start = 0;
      tick();
      reset = 0;
      tick();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_product", 32'(product), 0);
      reset = 1;
      for (int i = 0; i < WIDTH + 3; i++) begin
         chk("abort_no_done", 32'(done), 0);
         chk("abort_product_hold", 32'(product), 0);
         tick();
      end

      // Exhaustive operand sweep with start held high.
      b2b_mode = 1;
      last_done_cyc = -1;
      start = 1;
      for (int k = 0; k < 256; k++) begin
         logic [WIDTH-1:0] mc, mp;
         int p;
         mc = 4'(k >> 4); mp = 4'(k);
         p = int'($signed(mc)) * int'($signed(mp));
         mcand = mc; mplr = mp;
         sb.push_back(8'(p));
         tick();                    // acceptance edge
         chk("b2b_accept", 32'(busy), 1);
         mcand = ~mc; mplr = mp + 4'd5;
         if (k == 255) start = 0;
         repeat (WIDTH + 1) @(posedge clk);
         #1;
      end
      b2b_mode = 0;
      repeat (3) tick();
      chk("scoreboard_empty", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
